stress_eval_multi: RTL and testbench
====================================

# stress_eval_multi

Parametrised stress evaluator for the rocking controller: samples N_CH stress-related sensor channels (heart rate, cry volume, ...) on the `slow` tick and averages each channel over a window of 2^LOG_AVG ticks. At each window end it compares every channel's average with that channel's previous window average and flags the channel "decreased" or "equal" within a tolerance. Per-channel flags are combined into `gedaald`/`gelijk` by a selectable any/all mode under an enable mask. It replaces the single-channel heart-only stress path and feeds the rocking-decision FSM.

## Interface
- N_CH, 2, number of sensor channels (≥1)
- W, 8, sample width, unsigned
- LOG_AVG, 2, log2 of samples per window (≥0)
- TOL, 2, equality tolerance, unsigned, < 2^W
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- slow  in  1  sample strobe; every cycle it is high counts as one sample
- ch_en  in  N_CH  channel enable mask for the combined outputs
- mode  in  1  0 = any enabled channel (OR), 1 = all enabled channels (AND)
- data  in  N_CH*W  packed samples, channel c at [c*W +: W]
- ch_gedaald  out  N_CH  per-channel "average decreased beyond TOL"
- ch_gelijk  out  N_CH  per-channel "|change| ≤ TOL"
- gedaald  out  1  combined decreased flag
- gelijk  out  1  combined equal flag
- klaar  out  1  one-cycle pulse: new comparison result published

## Operation
- State: shared sample counter cnt (LOG_AVG bits), per-channel accumulator acc[c] (W+LOG_AVG bits, no overflow possible), per-channel prev[c] (W bits), primed bit.
- slow high, cnt < 2^LOG_AVG−1: acc[c] += data[c] for all c (enabled or not); cnt++.
- slow high, cnt = 2^LOG_AVG−1 (window end): avg[c] = (acc[c] + data[c]) >> LOG_AVG (truncating); acc ← 0; cnt ← 0; prev[c] ← avg[c]; primed ← 1.
- At window end with primed = 1: per channel, d = prev[c] − avg[c] computed at W+1 bits signed; ch_gedaald[c] = (d > TOL); ch_gelijk[c] = (|d| ≤ TOL); a rise beyond TOL gives both 0. The two flags are mutually exclusive. klaar = 1 for the following cycle.
- At window end with primed = 0 (first window after reset): prev is loaded only; flags stay 0; no klaar.
- Combine (combinational from registered flags and current ch_en/mode). mode 0: gedaald = OR(ch_gedaald & ch_en), gelijk = OR(ch_gelijk & ch_en). mode 1: gedaald = AND over enabled channels of ch_gedaald, gelijk likewise. ch_en = 0: gedaald = gelijk = 0 in both modes.
- Per-channel flags hold their value until the next primed window end.
- LOG_AVG = 0: every slow tick is a window end.

## Timing
- Reset values: cnt = 0, acc = 0, prev = 0, primed = 0, ch_gedaald = ch_gelijk = 0, gedaald = gelijk = 0, klaar = 0.
- Latency: the flags and klaar are registered on the same clk edge that samples the final slow of a window. They are visible in the next cycle; klaar is high for exactly that one cycle.
- Combined outputs follow changes to ch_en/mode in the same cycle, with no register.
- reset takes priority over slow in the same cycle. A reset mid-window discards the partial window, and the next full window is unprimed again.
- A slow held high for k cycles counts as k samples.

## Test plan
- Reset: assert reset 2 cycles with slow toggling -> all outputs 0; the first window after release yields no klaar and flags 0.
- Decrease: N_CH=2, LOG_AVG=2, TOL=2, ch_en=2'b01, mode 0; ch0 window 1 = 100×4, window 2 = 90×4 -> klaar one cycle after the 8th tick, ch_gedaald=2'b01, gedaald=1, gelijk=0.
- Tolerance edges: ch0 prev avg 100, next avg 102 -> ch_gelijk[0]=1; then avg 105 (d=−3) -> both flags 0; then avg 102 (d=3) -> ch_gedaald[0]=1.
- Mode/mask: ch0 decreases, ch1 rises; mode 1, ch_en=2'b11 -> gedaald=0; mode 0 -> gedaald=1; mode 1, ch_en=2'b01 -> gedaald=1; ch_en=0 -> gedaald=gelijk=0.
- Truncation: primed ch0, samples 1,1,1,2 -> avg 1 (acc 5 >> 2), compared against prev 1 -> ch_gelijk[0]=1.
- Reset mid-window: after 2 of 4 ticks of window 3, pulse reset -> flags cleared; the next window is unprimed (no klaar); the following window compares correctly.

Source files
------------

// File: rtl/stress_eval_multi.sv
// stress_eval_multi: per-channel windowed averaging of stress sensors with decrease/equal flags, combined any/all under a mask
//   clk, reset (sync, active-high), slow (sample strobe), ch_en (combine mask), mode (0 any, 1 all),
//   data (N_CH packed W-bit samples) -> ch_gedaald/ch_gelijk (registered per-channel flags),
//   gedaald/gelijk (combinational combine), klaar (one-cycle result pulse)
module stress_eval_multi #(
  parameter int N_CH = 2,
  parameter int W = 8,
  parameter int LOG_AVG = 2,
  parameter int TOL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slow,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              mode,
  input  logic [N_CH*W-1:0] data,
  output logic [N_CH-1:0]   ch_gedaald,
  output logic [N_CH-1:0]   ch_gelijk,
  output logic              gedaald,
  output logic              gelijk,
  output logic              klaar
);
  localparam int AW = W + LOG_AVG;
  localparam int CW = LOG_AVG > 0 ? LOG_AVG : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG_AVG) - 1);
  logic [CW-1:0] cnt;
  logic primed;
  logic [N_CH-1:0][AW-1:0] acc, sum;
  logic [N_CH-1:0][W-1:0] prev, avg;
  logic [N_CH-1:0][W:0] d, mag;
  logic [N_CH-1:0] dec, eq;
  // d = prev - avg as a W+1-bit two's-complement value; positive means the average fell
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sum[c] = acc[c] + AW'(data[c*W +: W]);
      avg[c] = W'(sum[c] >> LOG_AVG);
      d[c] = {1'b0, prev[c]} - {1'b0, avg[c]};
      mag[c] = d[c][W] ? -d[c] : d[c];
      dec[c] = !d[c][W] && d[c] > (W+1)'(TOL);
      eq[c] = mag[c] <= (W+1)'(TOL);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      prev <= '0;
      primed <= 1'b0;
      ch_gedaald <= '0;
      ch_gelijk <= '0;
      klaar <= 1'b0;
    end else begin
      klaar <= 1'b0;
      if (slow) begin
        if (cnt == LAST) begin
          cnt <= '0;
          acc <= '0;
          prev <= avg;
          primed <= 1'b1;
          // the first window after reset only seeds prev
          if (primed) begin
            ch_gedaald <= dec;
            ch_gelijk <= eq;
            klaar <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
          acc <= sum;
        end
      end
    end
  end
  // all-mode treats masked channels as true, but an empty mask forces 0
  assign gedaald = mode ? (|ch_en && &(ch_gedaald | ~ch_en)) : |(ch_gedaald & ch_en);
  assign gelijk = mode ? (|ch_en && &(ch_gelijk | ~ch_en)) : |(ch_gelijk & ch_en);
endmodule

// File: tb/tb_stress_eval_multi.sv
// tb_stress_eval_multi: table-driven windows with a flag scoreboard plus hand-written reset/hold sequences
module tb_stress_eval_multi;
  logic clk = 1'b0;
  logic reset, slow, mode, klaar, gedaald, gelijk;
  logic [1:0] ch_en, ch_gedaald, ch_gelijk;
  logic [15:0] data;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  typedef struct {
    logic [31:0] s0, s1;
    logic [1:0] en;
    logic md, k;
    logic [1:0] cgd, cgl;
    logic gd, gl;
  } vec_t;
  vec_t tbl[11];

  stress_eval_multi #(.N_CH(2), .W(8), .LOG_AVG(2), .TOL(2)) dut (
    .clk(clk), .reset(reset), .slow(slow), .ch_en(ch_en), .mode(mode), .data(data),
    .ch_gedaald(ch_gedaald), .ch_gelijk(ch_gelijk), .gedaald(gedaald), .gelijk(gelijk), .klaar(klaar)
  );

  always #5 clk = ~clk;

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task sample_out(input string name);
    logic [3:0] e;
    if (klaar) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_klaar actual 1 required 0", name);
      end else begin
        e = sb.pop_front();
        chk({name, "_sb_flags"}, {28'd0, ch_gedaald, ch_gelijk}, {28'd0, e});
      end
    end
  endtask

  task tick(input logic [7:0] a, input logic [7:0] b, input string name);
    @(negedge clk);
    data = {b, a};
    slow = 1'b1;
    @(negedge clk);
    slow = 1'b0;
    sample_out(name);
  endtask

  task window(input logic [31:0] a, input logic [31:0] b, input logic k,
              input logic [1:0] cgd, input logic [1:0] cgl, input string name);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && k) sb.push_back({cgd, cgl});
      tick(a[i*8 +: 8], b[i*8 +: 8], name);
    end
    chk({name, "_klaar"}, {31'd0, klaar}, {31'd0, k});
    chk({name, "_drain"}, sb.size(), 0);
    chk({name, "_ch"}, {28'd0, ch_gedaald, ch_gelijk}, {28'd0, cgd, cgl});
    @(negedge clk);
    chk({name, "_klaar_width"}, {31'd0, klaar}, 0);
  endtask

  task comb(input logic [1:0] en, input logic md, input logic gd, input logic gl, input string name);
    ch_en = en;
    mode = md;
    #1;
    chk(name, {30'd0, gedaald, gelijk}, {30'd0, gd, gl});
  endtask

  initial begin
    reset = 1'b1;
    slow = 1'b0;
    ch_en = 2'b11;
    mode = 1'b1;
    data = 16'h3232;
    @(negedge clk);
    slow = 1'b1;
    @(negedge clk);
    slow = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {25'd0, ch_gedaald, ch_gelijk, gedaald, gelijk, klaar}, 0);
    reset = 1'b0;
    tbl[0]  = '{32'h64646464, 32'h32323232, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{32'h5A5A5A5A, 32'h32323232, 2'b01, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[2]  = '{32'h64646464, 32'h32323232, 2'b11, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1};
    tbl[3]  = '{32'h66666666, 32'h32323232, 2'b11, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1};
    tbl[4]  = '{32'h69696969, 32'h32323232, 2'b11, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0};
    tbl[5]  = '{32'h66666666, 32'h32323232, 2'b11, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1};
    tbl[6]  = '{32'h5A5A5A5A, 32'h3C3C3C3C, 2'b11, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{32'h01010101, 32'h3C3C3C3C, 2'b01, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{32'h02010101, 32'h3E3D3C3C, 2'b11, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b1};
    tbl[9]  = '{32'hFFFFFFFF, 32'h00000000, 2'b11, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[10] = '{32'h00000000, 32'h00000000, 2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      window(tbl[i].s0, tbl[i].s1, tbl[i].k, tbl[i].cgd, tbl[i].cgl, $sformatf("v%0d", i));
      comb(tbl[i].en, tbl[i].md, tbl[i].gd, tbl[i].gl, $sformatf("v%0d_comb", i));
      if (i == 6) begin
        comb(2'b11, 1'b0, 1'b1, 1'b0, "mask_any_all");
        comb(2'b01, 1'b1, 1'b1, 1'b0, "mask_all_ch0");
        comb(2'b10, 1'b1, 1'b0, 1'b0, "mask_all_ch1");
        comb(2'b00, 1'b0, 1'b0, 1'b0, "mask_none_any");
        comb(2'b00, 1'b1, 1'b0, 1'b0, "mask_none_all");
      end
    end
    tick(8'h32, 8'h32, "rst_mid");
    tick(8'h32, 8'h32, "rst_mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_clear", {29'd0, ch_gedaald, ch_gelijk, klaar} >> 0, 0);
    comb(2'b11, 1'b0, 1'b0, 1'b0, "rst_mid_comb");
    window(32'h50505050, 32'h50505050, 1'b0, 2'b00, 2'b00, "post_rst_unprimed");
    window(32'h46464646, 32'h51515151, 1'b1, 2'b01, 2'b10, "post_rst_primed");
    @(negedge clk);
    data = 16'h5A46;
    slow = 1'b1;
    sb.push_back(4'b0001);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j < 3) chk("held_no_klaar", {31'd0, klaar}, 0);
    end
    slow = 1'b0;
    sample_out("held");
    chk("held_klaar", {31'd0, klaar}, 1);
    chk("held_drain", sb.size(), 0);
    @(negedge clk);
    chk("held_klaar_width", {31'd0, klaar}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
